seq_alu_bcd: RTL and testbench

Multi-cycle, parametrised-width calculator ALU that converts its result to BCD in hardware. Arithmetic is iterative: shift-add multiply, restoring divide, and sequential double-dabble conversion at one shift per clock. A start/busy/done handshake sits between the operand registers and the seven-segment display path. It is the area-reduced, width-scalable successor to the combinational op-code ALU, and adds signed-magnitude subtract, remainder, and error flags.

---
 rtl/seq_alu_bcd.sv | 210 +++++++++++++++++++++
 tb/tb_seq_alu_bcd.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu_bcd.sv
// Multi-cycle calculator ALU with a binary-to-BCD back end.
// ADD/SUB resolve in one cycle, MUL is shift-add, DIV/MOD is restoring
// division, and the result is converted by serial double dabble.
// Results are presented only on entry to DONE and hold until the next completion.
module seq_alu_bcd #(
    parameter int W      = 8,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [2:0]            opcode,
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    output logic                  busy,
    output logic                  done,
    output logic [2*W-1:0]        result_bin,
    output logic [4*DIGITS-1:0]   result_bcd,
    output logic [W-1:0]          result_rem,
    output logic                  neg,
    output logic                  err
);

    localparam int W2    = 2 * W;
    localparam int BW    = 4 * DIGITS;
    localparam int CW    = BW + W2;
    localparam int CNT_W = $clog2(W2) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_CONV = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(W2 - 1);

    // One double-dabble step: bias every BCD nibble >= 5 by 3, then shift left.
    function automatic logic [CW-1:0] dabble_step(input logic [CW-1:0] v);
        logic [CW-1:0] t;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (t[W2+4*i +: 4] >= 4'd5)
                t[W2+4*i +: 4] = t[W2+4*i +: 4] + 4'd3;
        end
        return {t[CW-2:0], 1'b0};
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    logic [2:0]       op_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [W2-1:0]    acc;
    logic [W2-1:0]    mcand;
    logic [W-1:0]     mplier;
    logic [W-1:0]     pr;
    logic [W-1:0]     dq;
    logic [W2-1:0]    res_w;
    logic [W-1:0]     rem_w;
    logic             neg_w;
    logic [CW-1:0]    conv;

    logic             accept;
    logic             is_err;
    logic             last_calc;
    logic             last_conv;
    logic [W2-1:0]    acc_nx;
    logic             neg_nx;
    logic [W:0]       shifted;
    logic [W:0]       diff;
    logic             qbit;
    logic [W-1:0]     pr_nx;
    logic [W-1:0]     dq_nx;
    logic [W2-1:0]    res_nx;
    logic [W-1:0]     rem_nx;
    logic [CW-1:0]    conv_nx;

    assign busy    = (state == S_CALC) || (state == S_CONV);
    assign done    = (state == S_DONE);
    assign accept  = start && ((state == S_IDLE) || (state == S_DONE));
    assign is_err  = (opcode > OP_MOD) ||
                     (((opcode == OP_DIV) || (opcode == OP_MOD)) && (b == '0));
    assign last_calc = ((op_r == OP_ADD) || (op_r == OP_SUB)) ? (cnt == '0)
                                                             : (cnt == ITER_LAST);
    assign last_conv = (cnt == CONV_LAST);
    assign conv_nx   = dabble_step(conv);

    // Next-step arithmetic for the CALC state: add/sub, one MUL partial product, one DIV quotient bit.
    always_comb begin
        acc_nx  = acc;
        neg_nx  = 1'b0;
        shifted = {pr, dq[W-1]};
        diff    = shifted - {1'b0, b_r};
        qbit    = (shifted >= {1'b0, b_r});
        pr_nx   = qbit ? diff[W-1:0] : shifted[W-1:0];
        dq_nx   = {dq[W-2:0], qbit};
        case (op_r)
            OP_ADD: acc_nx = W2'(a_r) + W2'(b_r);
            OP_SUB: begin
                if (a_r >= b_r) begin
                    acc_nx = W2'(a_r) - W2'(b_r);
                end else begin
                    acc_nx = W2'(b_r) - W2'(a_r);
                    neg_nx = 1'b1;
                end
            end
            OP_MUL: acc_nx = mplier[0] ? (acc + mcand) : acc;
            default: acc_nx = acc;
        endcase
        case (op_r)
            OP_DIV:  res_nx = W2'(dq_nx);
            OP_MOD:  res_nx = W2'(pr_nx);
            default: res_nx = acc_nx;
        endcase
        rem_nx = ((op_r == OP_DIV) || (op_r == OP_MOD)) ? pr_nx : '0;
    end

    // Control FSM and per-state cycle counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    cnt <= '0;
                    if (accept)
                        state <= is_err ? S_DONE : S_CALC;
                    else
                        state <= S_IDLE;
                end
                S_CALC: begin
                    if (last_calc) begin
                        state <= S_CONV;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (last_conv) begin
                        state <= S_DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Datapath: capture operands on accept, iterate in CALC, shift-convert in CONV.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_r   <= opcode;
            a_r    <= a;
            b_r    <= b;
            acc    <= '0;
            mcand  <= W2'(b);
            mplier <= a;
            pr     <= '0;
            dq     <= a;
        end else if (state == S_CALC) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            pr     <= pr_nx;
            dq     <= dq_nx;
            if (last_calc) begin
                res_w <= res_nx;
                rem_w <= rem_nx;
                neg_w <= neg_nx;
                conv  <= {{BW{1'b0}}, res_nx};
            end
        end else if (state == S_CONV) begin
            conv <= conv_nx;
        end
    end

    // Visible results: loaded only on the edge entering DONE (error or end of conversion).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result_bin <= '0;
            result_bcd <= '0;
            result_rem <= '0;
            neg        <= 1'b0;
            err        <= 1'b0;
        end else if (accept && is_err) begin
            result_bin <= '0;
            result_bcd <= '0;
            result_rem <= '0;
            neg        <= 1'b0;
            err        <= 1'b1;
        end else if ((state == S_CONV) && last_conv) begin
            result_bin <= res_w;
            result_bcd <= conv_nx[CW-1:W2];
            result_rem <= rem_w;
            neg        <= neg_w;
            err        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu_bcd.sv
// Directed bench for seq_alu_bcd (W=8, DIGITS=5) with hand-computed expectations.
module tb_seq_alu_bcd;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  opcode = 3'd0;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        busy;
    logic        done;
    logic [15:0] result_bin;
    logic [19:0] result_bcd;
    logic [7:0]  result_rem;
    logic        neg;
    logic        err;

    int checks = 0;
    int failures = 0;

    seq_alu_bcd #(.W(8), .DIGITS(5)) dut (
        .clk(clk), .rstn(rstn), .start(start), .opcode(opcode), .a(a), .b(b),
        .busy(busy), .done(done), .result_bin(result_bin), .result_bcd(result_bcd),
        .result_rem(result_rem), .neg(neg), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation; lat = edges after the accepting edge until done is seen.
    task automatic run_op(input logic [2:0] op, input logic [7:0] aa, input logic [7:0] bb,
                          input int pulse_at, output int lat, output int busy_cyc, output int chg);
        logic [15:0] bin0;
        bin0 = result_bin;
        @(negedge clk);
        opcode = op; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; opcode = 3'd2; a = 8'($urandom); b = 8'($urandom);
        lat = 0; busy_cyc = busy ? 1 : 0; chg = 0;
        while (!done && lat < 200) begin
            if (lat == pulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (busy) busy_cyc++;
            if (!done && result_bin !== bin0) chg = 1;
        end
    endtask

    int lat, bc, chg, extra;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_bin", result_bin, 0);
        check_eq("rst_bcd", result_bcd, 0);
        check_eq("rst_err", err, 0);
        @(negedge clk); rstn = 1'b1;

        // ADD
        run_op(3'b000, 8'd200, 8'd100, -1, lat, bc, chg);
        check_eq("add_lat", lat, 17);
        check_eq("add_busy_cycles", bc, 17);
        check_eq("add_done", done, 1);
        check_eq("add_bin", result_bin, 300);
        check_eq("add_bcd", result_bcd, 20'h00300);
        check_eq("add_neg", neg, 0);
        check_eq("add_err", err, 0);
        check_eq("add_rem", result_rem, 0);
        @(posedge clk); #1;
        check_eq("done_pulse_low", done, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("hold_bin", result_bin, 300);
        run_op(3'b000, 8'd255, 8'd255, -1, lat, bc, chg);
        check_eq("add_max_bcd", result_bcd, 20'h00510);

        // SUB
        run_op(3'b001, 8'd5, 8'd9, -1, lat, bc, chg);
        check_eq("sub_neg_lat", lat, 17);
        check_eq("sub_neg_bin", result_bin, 4);
        check_eq("sub_neg_flag", neg, 1);
        check_eq("sub_neg_bcd", result_bcd, 20'h00004);
        run_op(3'b001, 8'd9, 8'd9, -1, lat, bc, chg);
        check_eq("sub_eq_bin", result_bin, 0);
        check_eq("sub_eq_neg", neg, 0);

        // MUL with an ignored start during busy
        run_op(3'b010, 8'd255, 8'd255, 5, lat, bc, chg);
        check_eq("mul_lat", lat, 24);
        check_eq("mul_bin", result_bin, 65025);
        check_eq("mul_bcd", result_bcd, 20'h65025);
        check_eq("mul_no_midop_change", chg, 0);
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check_eq("mul_extra_done", extra, 0);

        // DIV then back-to-back MOD from the DONE cycle
        run_op(3'b011, 8'd200, 8'd7, -1, lat, bc, chg);
        check_eq("div_lat", lat, 24);
        check_eq("div_bin", result_bin, 28);
        check_eq("div_rem", result_rem, 4);
        check_eq("div_bcd", result_bcd, 20'h00028);
        run_op(3'b100, 8'd200, 8'd7, -1, lat, bc, chg);
        check_eq("mod_b2b_lat", lat, 24);
        check_eq("mod_bin", result_bin, 4);
        check_eq("mod_rem", result_rem, 4);
        check_eq("mod_bcd", result_bcd, 20'h00004);
        run_op(3'b011, 8'd255, 8'd16, -1, lat, bc, chg);
        check_eq("div2_bin", result_bin, 15);
        check_eq("div2_rem", result_rem, 15);
        check_eq("div2_bcd", result_bcd, 20'h00015);

        // Errors
        run_op(3'b001, 8'd3, 8'd200, -1, lat, bc, chg);
        check_eq("sub2_bin", result_bin, 197);
        check_eq("sub2_neg", neg, 1);
        run_op(3'b011, 8'd50, 8'd0, -1, lat, bc, chg);
        check_eq("div0_lat", lat, 0);
        check_eq("div0_err", err, 1);
        check_eq("div0_bin", result_bin, 0);
        check_eq("div0_bcd", result_bcd, 0);
        check_eq("div0_rem", result_rem, 0);
        check_eq("div0_neg", neg, 0);
        run_op(3'b111, 8'd3, 8'd3, -1, lat, bc, chg);
        check_eq("badop_lat", lat, 0);
        check_eq("badop_err", err, 1);
        check_eq("badop_bin", result_bin, 0);
        run_op(3'b000, 8'd1, 8'd1, -1, lat, bc, chg);
        check_eq("clr_err", err, 0);
        check_eq("clr_bcd", result_bcd, 20'h00002);

        // Reset in the middle of MUL
        @(negedge clk);
        opcode = 3'b010; a = 8'd123; b = 8'd45; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("pre_rst_busy", busy, 1);
        #2 rstn = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_bin", result_bin, 0);
        check_eq("midrst_bcd", result_bcd, 0);
        check_eq("midrst_rem", result_rem, 0);
        check_eq("midrst_flags", {neg, err}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        extra = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (busy || done || result_bin != 0) extra++;
        end
        check_eq("post_rst_quiet", extra, 0);
        run_op(3'b000, 8'd0, 8'd0, -1, lat, bc, chg);
        check_eq("post_rst_add_lat", lat, 17);
        check_eq("post_rst_add_bcd", result_bcd, 0);
        check_eq("post_rst_add_done", done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
